// File: rtl/mux_rr_pkg.sv
// Shared types and sizes for the 16-requester round-robin mux scheduler.
// Optional lock input is enabled by defining MUX_RR_LOCK_EN.
package mux_rr_pkg;

    localparam int N_REQ  = 16;
    localparam int SEL_W  = 4;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/mux_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping mod 16.
module mux_rr_pick
    import mux_rr_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] off;

    // NOTE: every variable written in always_comb is given a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        off = '0;
        // Scanning downwards lets the lowest rotated offset win.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[ptr + SEL_W'(i)]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = ptr + off;

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler driving the select of a shared 16:1 mux, with a
// bounded hold time and a dead RELEASE cycle. Define MUX_RR_LOCK_EN for lock.
module mux_rr_scheduler
    import mux_rr_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
`ifdef MUX_RR_LOCK_EN
    input  logic             lock,
`endif
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             valid,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic               lock_w;
    logic               timeout;

`ifdef MUX_RR_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = 1'b0;
`endif

    mux_rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // A locked grantee neither times out nor advances its hold count.
    assign timeout = (hold_q == HOLD_W'(MAX_HOLD - 1)) && !lock_w;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d           = GRANT;
                    sel_d             = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    valid_d           = 1'b1;
                    busy_d            = 1'b1;
                    hold_d            = '0;
                end
            end
            GRANT: begin
                if (!lock_w) begin
                    hold_d = hold_q + 1'b1;
                end
                if (done || !req[sel_q] || timeout) begin
                    state_d = RELEASE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                    ptr_d   = sel_q + 1'b1;
                end
            end
            RELEASE: begin
                // sel is held here so the mux input never moves while valid=1.
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign sel   = sel_q;
    assign grant = grant_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares one 16:1 single-bit mux among 16 requesters and drives its 4-bit select.
- Requester i raises req[i]; the block grants one requester at a time and presents its index on sel with a qualifying valid.
- It sits between the requester bank and the combinational 16:1 mux; the mux output is only meaningful while valid=1.
- Bounded hold time guarantees fairness.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16 to match the 4-bit select (not a free parameter).
- SEL_W, 4, select width = clog2(N_REQ).
- MAX_HOLD, 8, maximum consecutive GRANT cycles per grant; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  16  request vector; bit i = requester i wants the mux.
- done  input  1  current grantee finished; sampled only in GRANT.
- sel  output  4  registered mux select = index of current grantee.
- grant  output  16  registered one-hot grant; all-zero when not granting.
- valid  output  1  registered; 1 while in GRANT (sel and mux output usable).
- busy  output  1  registered; 1 in GRANT or RELEASE.

Behaviour:
- All outputs registered. Reset values: sel=0, grant=0, valid=0, busy=0, state=IDLE, priority pointer ptr=0, hold counter=0.
- States:
  - IDLE: if req!=0, pick the first set bit searching ptr, ptr+1, ..., ptr+15 (mod 16).
    - Next edge: sel=winner, grant=1<<winner, valid=1, busy=1, hold=0, go to GRANT.
    - Latency req->valid = 1 cycle.
    - If req==0, stay in IDLE; outputs unchanged at idle values.
  - GRANT: hold increments each cycle. Release condition = done OR req[sel]==0 OR hold==MAX_HOLD-1.
    - On release, next edge: valid=0, grant=0, ptr=(sel+1) mod 16, go to RELEASE.
    - sel keeps the old index in RELEASE.
  - RELEASE: single dead cycle (busy=1, valid=0) so the mux select never changes while valid=1.
    - Next edge: go to IDLE, busy=0.
    - Back-to-back grants therefore cost 2 idle-valid cycles; minimum period between grants = 3 cycles with MAX_HOLD=1.
- Simultaneous events:
  - done + timeout + req drop in the same cycle -> one release; ptr advances by exactly one position past the grantee.
  - Requests arriving in RELEASE are considered in the following IDLE cycle.
- Fairness: a requester continuously asserting req waits at most 15 x (MAX_HOLD+2) cycles.
- Wrap-around: ptr modulo 16, so grantee 15 -> ptr=0. Hold counter is 8 bits and saturates via the release condition; it never wraps.
- done outside GRANT is ignored.
- Reset asserted mid-GRANT: at the next edge all outputs return to reset values, ptr=0, state=IDLE; no RELEASE cycle.
- req bits are assumed synchronous to clk; no internal synchronizers.

Optional Feature:
- Macro MUX_RR_LOCK_EN.
- Defined: extra input port lock (1 bit). While lock=1 in GRANT, the MAX_HOLD timeout is suppressed and the hold counter freezes; done or a req drop still releases. lock outside GRANT is ignored.
- Undefined: no lock port; the timeout is always active.

Decomposition:
- Package mux_rr_pkg:
  - state enum {IDLE, GRANT, RELEASE} (2 bits);
  - localparams N_REQ=16, SEL_W=4, HOLD_W=8.
- Sub-module mux_rr_pick (combinational):
  - inputs req[15:0], ptr[3:0]; outputs any, idx[3:0];
  - rotating-priority encoder (rotate right by ptr, priority-encode, add ptr mod 16).
- FSM, counters and output registers live in the top.

Test Plan:
- Reset then req=16'h0001 held, done=0, MAX_HOLD=8 -> valid=1 and sel=0 one cycle after req; valid drops after 8 GRANT cycles; RELEASE, IDLE, then re-grant sel=0.
- req=16'h8001 held, ptr=0 after reset -> grant order sel=0, 15, 0, 15; each grant 8 cycles; exactly 2 valid=0 cycles between grants.
- req=16'hFFFF, done pulsed on the 2nd GRANT cycle of each grant -> sel sequence 0,1,2,...,15,0; each valid pulse 2 cycles long.
- Grantee 5 drops req[5] on hold=3 while req[9]=1 -> release on the next edge; after RELEASE/IDLE, sel=9.
- Assert rst during GRANT of sel=7 -> next edge sel=0, grant=0, valid=0, busy=0; after reset with req=16'h0080, grant=16'h0080.
- With MUX_RR_LOCK_EN, lock=1, req=16'h0004 for 20 cycles -> valid stays 1 all 20 cycles; done=1 -> release next edge.
